// File: rtl/hawk_wrr_sched.sv
// Weighted round-robin scheduler: shares one single-outstanding server among N requesters.
// Per-requester weights set how many consecutive grants a requester may take before the pointer advances.
module hawk_wrr_sched #(
  parameter int unsigned N     = 4,
  parameter int unsigned BREQ  = 64,
  parameter int unsigned BRSP  = 64,
  parameter int unsigned WBITS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N-1:0]           req_valid_i,
  input  logic [N*BREQ-1:0]      req_data_i,
  output logic [N-1:0]           req_ready_o,
  input  logic [N*WBITS-1:0]     weight_i,
  output logic [N-1:0]           rsp_valid_o,
  output logic [BRSP-1:0]        rsp_data_o,
  output logic                   srv_valid_o,
  output logic [BREQ-1:0]        srv_req_o,
  input  logic                   srv_ready_i,
  input  logic [BRSP-1:0]        srv_rsp_i,
  input  logic                   srv_done_i,
  output logic [$clog2(N)-1:0]   grant_id_o,
  output logic                   busy_o
);

  localparam int unsigned PW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [WBITS-1:0]  r_cnt;
  logic [BREQ-1:0]   r_srv_req;
  logic [PW-1:0]     r_gid;

  logic              w_found;
  logic [PW-1:0]     w_g;
  logic [WBITS-1:0]  w_wt;
  logic [WBITS-1:0]  w_weff;
  logic [WBITS-1:0]  w_base;
  logic [WBITS:0]    w_n;
  logic [PW-1:0]     w_ptr_nxt;
  logic [WBITS-1:0]  w_cnt_nxt;
  logic              w_grant;
  logic              w_rsp_fire;

  // First valid requester scanning from r_ptr upward with wrap; modulo keeps non-power-of-two N in range.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_g     = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(r_ptr) + k) % N;
      if (!w_found && req_valid_i[idx]) begin
        w_found = 1'b1;
        w_g     = PW'(idx);
      end
    end
  end

  // Credit bookkeeping: a winner other than the pointer owner starts from zero credit.
  always_comb begin
    w_wt   = weight_i[w_g*WBITS +: WBITS];
    w_weff = (w_wt == '0) ? WBITS'(1) : w_wt;
    w_base = (w_g == r_ptr) ? r_cnt : '0;
    w_n    = {1'b0, w_base} + (WBITS+1)'(1);
    if (w_n >= {1'b0, w_weff}) begin
      w_ptr_nxt = (w_g == PW'(N-1)) ? '0 : w_g + PW'(1);
      w_cnt_nxt = '0;
    end else begin
      w_ptr_nxt = w_g;
      w_cnt_nxt = w_n[WBITS-1:0];
    end
  end

  assign w_grant    = rst_ni && (r_state == S_IDLE) && w_found;
  assign w_rsp_fire = rst_ni && (r_state == S_WAIT) && srv_done_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_srv_req <= '0;
      r_gid     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_srv_req <= req_data_i[w_g*BREQ +: BREQ];
            r_gid     <= w_g;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (srv_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (srv_done_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (w_grant) req_ready_o[w_g] = 1'b1;
    if (w_rsp_fire) begin
      rsp_valid_o[r_gid] = 1'b1;
      rsp_data_o         = srv_rsp_i;
    end
  end

  assign srv_valid_o = rst_ni && (r_state == S_ISSUE);
  assign busy_o      = rst_ni && (r_state == S_ISSUE || r_state == S_WAIT);
  assign srv_req_o   = r_srv_req;
  assign grant_id_o  = r_gid;

endmodule

// File: tb/tb_hawk_wrr_sched.sv
// Directed self-checking bench for hawk_wrr_sched (N=4): latency, grant ordering, backpressure, wrap, reset.
module tb_hawk_wrr_sched;

  localparam int unsigned N     = 4;
  localparam int unsigned BREQ  = 64;
  localparam int unsigned BRSP  = 64;
  localparam int unsigned WBITS = 4;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [N-1:0]         req_valid_i;
  logic [N*BREQ-1:0]    req_data_i;
  logic [N-1:0]         req_ready_o;
  logic [N*WBITS-1:0]   weight_i;
  logic [N-1:0]         rsp_valid_o;
  logic [BRSP-1:0]      rsp_data_o;
  logic                 srv_valid_o;
  logic [BREQ-1:0]      srv_req_o;
  logic                 srv_ready_i;
  logic [BRSP-1:0]      srv_rsp_i;
  logic                 srv_done_i;
  logic [1:0]           grant_id_o;
  logic                 busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  hawk_wrr_sched #(.N(N), .BREQ(BREQ), .BRSP(BRSP), .WBITS(WBITS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .weight_i    (weight_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .srv_valid_o (srv_valid_o),
    .srv_req_o   (srv_req_o),
    .srv_ready_i (srv_ready_i),
    .srv_rsp_i   (srv_rsp_i),
    .srv_done_i  (srv_done_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lands 2 time units after the rising edge; inputs driven here are away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    srv_ready_i = 1'b0;
    srv_done_i  = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  // Advances cycles until a grant appears, bounded; a missing grant fails the caller's check.
  task automatic wait_grant();
    int k = 0;
    while (req_ready_o == '0 && k < 8) begin
      tick();
      #1;
      k++;
    end
  endtask

  initial begin
    logic [3:0]  ord_eq [6]  = '{0, 1, 2, 3, 0, 1};
    logic [3:0]  ord_w  [10] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};
    logic [3:0]  ord_wr [3]  = '{0, 2, 0};
    logic [63:0] held;

    rst_ni      = 1'b0;
    req_valid_i = 4'b1111;
    req_data_i  = '0;
    weight_i    = 16'h1111;
    srv_ready_i = 1'b0;
    srv_rsp_i   = '0;
    srv_done_i  = 1'b0;
    tick();
    #1;
    chk("rst_ready",   req_ready_o, 0);
    chk("rst_srv_val", srv_valid_o, 0);
    chk("rst_busy",    busy_o, 0);
    chk("rst_gid",     grant_id_o, 0);
    chk("rst_srv_req", srv_req_o, 0);
    chk("rst_rsp",     rsp_valid_o, 0);
    do_reset();

    // Single request with minimum latency
    req_data_i[1*BREQ +: BREQ] = 64'hA5;
    req_valid_i = 4'b0010;
    srv_ready_i = 1'b1;
    #1;
    chk("single_ready", req_ready_o, 4'b0010);
    tick();
    req_valid_i = '0;
    #1;
    chk("single_srv_val", srv_valid_o, 1);
    chk("single_srv_req", srv_req_o, 64'hA5);
    chk("single_gid",     grant_id_o, 1);
    chk("single_busy",    busy_o, 1);
    tick();
    srv_done_i = 1'b1;
    srv_rsp_i  = 64'h3C;
    #1;
    chk("single_rsp_val", rsp_valid_o, 4'b0010);
    chk("single_rsp_dat", rsp_data_o, 64'h3C);
    chk("single_srv_lo",  srv_valid_o, 0);
    tick();
    srv_done_i = 1'b0;
    #1;
    chk("single_rsp_off", rsp_valid_o, 0);
    chk("single_dat_off", rsp_data_o, 0);
    chk("single_idle",    busy_o, 0);

    // Equal weights, all valid, server always ready and done next cycle
    do_reset();
    weight_i    = 16'h1111;
    req_valid_i = 4'b1111;
    srv_ready_i = 1'b1;
    srv_done_i  = 1'b1;
    #1;
    foreach (ord_eq[i]) begin
      wait_grant();
      chk($sformatf("eq_grant%0d", i), req_ready_o, 4'b0001 << ord_eq[i]);
      tick();
      #1;
    end

    // Weighted: requester0=3, requester1=1, requester2=0 (acts as 1), requester3=2
    do_reset();
    weight_i    = {4'd2, 4'd0, 4'd1, 4'd3};
    req_valid_i = 4'b1111;
    srv_ready_i = 1'b1;
    srv_done_i  = 1'b1;
    #1;
    foreach (ord_w[i]) begin
      wait_grant();
      chk($sformatf("wt_grant%0d", i), req_ready_o, 4'b0001 << ord_w[i]);
      tick();
      #1;
    end

    // Server backpressure with a done pulse during ISSUE
    do_reset();
    weight_i    = 16'h1111;
    srv_rsp_i   = 64'h77;
    req_data_i[2*BREQ +: BREQ] = 64'h1234_5678_9ABC_DEF0;
    req_valid_i = 4'b0100;
    #1;
    chk("bp_ready", req_ready_o, 4'b0100);
    held = 64'h1234_5678_9ABC_DEF0;
    for (int c = 0; c < 5; c++) begin
      tick();
      req_valid_i = 4'b1011;
      req_data_i  = {N*BREQ{1'b1}};
      srv_done_i  = (c == 2);
      #1;
      chk($sformatf("bp_srv_val%0d", c), srv_valid_o, 1);
      chk($sformatf("bp_srv_req%0d", c), srv_req_o, held);
      chk($sformatf("bp_noready%0d", c), req_ready_o, 0);
      chk($sformatf("bp_norsp%0d", c),   rsp_valid_o, 0);
    end
    tick();
    srv_done_i  = 1'b0;
    srv_ready_i = 1'b1;
    req_valid_i = '0;
    #1;
    chk("bp_accept_val", srv_valid_o, 1);
    tick();
    #1;
    chk("bp_wait_srv",  srv_valid_o, 0);
    chk("bp_wait_rsp",  rsp_valid_o, 0);
    chk("bp_wait_busy", busy_o, 1);
    tick();
    srv_done_i = 1'b1;
    #1;
    chk("bp_rsp_val", rsp_valid_o, 4'b0100);
    chk("bp_rsp_dat", rsp_data_o, 64'h77);
    tick();
    srv_done_i = 1'b0;
    #1;
    chk("bp_rsp_once", rsp_valid_o, 0);
    chk("bp_no_grant", req_ready_o, 0);

    // Wrap: a grant to requester 2 leaves ptr=3, cnt=0
    do_reset();
    weight_i    = 16'h1111;
    req_valid_i = 4'b0100;
    srv_ready_i = 1'b1;
    srv_done_i  = 1'b1;
    #1;
    chk("wrap_setup", req_ready_o, 4'b0100);
    tick();
    req_valid_i = 4'b0101;
    #1;
    foreach (ord_wr[i]) begin
      wait_grant();
      chk($sformatf("wrap_grant%0d", i), req_ready_o, 4'b0001 << ord_wr[i]);
      tick();
      #1;
    end

    // Reset while waiting for the server
    do_reset();
    weight_i    = 16'h1111;
    req_valid_i = 4'b0010;
    srv_ready_i = 1'b1;
    #1;
    chk("rw_grant", req_ready_o, 4'b0010);
    tick();
    tick();
    req_valid_i = '0;
    #1;
    chk("rw_in_wait", busy_o, 1);
    srv_done_i  = 1'b1;
    srv_rsp_i   = 64'hFF;
    req_valid_i = 4'b1111;
    rst_ni      = 1'b0;
    #1;
    chk("rw_rsp_val", rsp_valid_o, 0);
    chk("rw_rsp_dat", rsp_data_o, 0);
    chk("rw_busy",    busy_o, 0);
    chk("rw_srv_val", srv_valid_o, 0);
    chk("rw_ready",   req_ready_o, 0);
    chk("rw_gid",     grant_id_o, 0);
    chk("rw_srv_req", srv_req_o, 0);
    tick();
    tick();
    #1;
    chk("rw_hold_rsp", rsp_valid_o, 0);
    srv_done_i = 1'b0;
    rst_ni     = 1'b1;
    #1;
    chk("rw_first_grant", req_ready_o, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
